// File: rtl/batch_mac_engine_pkg.sv
// Shared types and sizing helpers for the batch multiply-accumulate engine.
package batch_mac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMult,
    StAcc,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Wide enough that COUNT worst-case products never overflow.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned count);
    return 2 * width + clog2(count);
  endfunction

endpackage

// File: rtl/batch_mac_engine_if.sv
// Job handshake, operand stream and result bus of the batch MAC engine.
interface batch_mac_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 18
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [AW-1:0]    acc_out;

  modport master (
    output start, a_in, b_in, in_valid,
    input  in_ready, busy, done, acc_out
  );

  modport slave (
    input  start, a_in, b_in, in_valid,
    output in_ready, busy, done, acc_out
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles.
module seq_mult_unit
  import batch_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               ready
);
  localparam int unsigned CntW = clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (go) begin
      mcand_q  <= (2*WIDTH)'(a);
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign prod  = prod_q;
  assign ready = (cnt_q == '0);

endmodule

// File: rtl/batch_mac_engine.sv
// Batch MAC engine: FSM, sign handling, pair counter and accumulator around seq_mult_unit.
module batch_mac_engine
  import batch_mac_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned COUNT  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  batch_mac_engine_if.slave bus
);
  localparam int unsigned AW  = acc_width(WIDTH, COUNT);
  localparam int unsigned CW  = clog2(COUNT + 1);
  localparam int unsigned MW  = clog2(WIDTH);

  state_e           state_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    pair_cnt_q;
  logic [MW-1:0]    bit_cnt_q;
  logic             neg_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;
  logic               go;
  logic [2*WIDTH-1:0] mult_prod;
  logic               mult_ready;
  logic [AW-1:0]      prod_ext;

  // Magnitude of the most negative value still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag  = bus.a_in;
    b_mag  = bus.b_in;
    neg_in = 1'b0;
    if (SIGNED) begin
      if (bus.a_in[WIDTH-1]) a_mag = -bus.a_in;
      if (bus.b_in[WIDTH-1]) b_mag = -bus.b_in;
      neg_in = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
    end
  end

  assign go       = (state_q == StLoad) && bus.in_valid;
  assign prod_ext = AW'(mult_prod);

  seq_mult_unit #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .a    (a_mag),
    .b    (b_mag),
    .prod (mult_prod),
    .ready(mult_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      pair_cnt_q <= '0;
      bit_cnt_q  <= '0;
      neg_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q      <= '0;
            pair_cnt_q <= '0;
            state_q    <= StLoad;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StLoad: begin
          if (bus.in_valid) begin
            neg_q      <= neg_in;
            bit_cnt_q  <= MW'(WIDTH - 1);
            state_q    <= StMult;
            in_ready_q <= 1'b0;
          end
        end
        StMult: begin
          if (bit_cnt_q == '0) begin
            state_q <= StAcc;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        StAcc: begin
          if (mult_ready) begin
            acc_q      <= neg_q ? acc_q - prod_ext : acc_q + prod_ext;
            pair_cnt_q <= pair_cnt_q + 1'b1;
            if (pair_cnt_q == CW'(COUNT - 1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StLoad;
              in_ready_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_out  = acc_q;

endmodule

// File: tb/tb_batch_mac_engine.sv
// Self-checking bench: three engine configurations driven from one shared stimulus port.
module tb_batch_mac_engine;
  import batch_mac_pkg::*;

  localparam int unsigned AW8 = acc_width(8, 4);
  localparam int unsigned AW4 = acc_width(4, 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batch_mac_engine_if #(.WIDTH(8), .AW(AW8)) if_u ();
  batch_mac_engine_if #(.WIDTH(8), .AW(AW8)) if_s ();
  batch_mac_engine_if #(.WIDTH(4), .AW(AW4)) if_c ();

  batch_mac_engine #(.WIDTH(8), .COUNT(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .bus(if_u.slave)
  );
  batch_mac_engine #(.WIDTH(8), .COUNT(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .bus(if_s.slave)
  );
  batch_mac_engine #(.WIDTH(4), .COUNT(1), .SIGNED(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  logic       start;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  int         sel;

  assign if_u.start    = start && (sel == 0);
  assign if_s.start    = start && (sel == 1);
  assign if_c.start    = start && (sel == 2);
  assign if_u.in_valid = in_valid && (sel == 0);
  assign if_s.in_valid = in_valid && (sel == 1);
  assign if_c.in_valid = in_valid && (sel == 2);
  assign if_u.a_in = a;
  assign if_u.b_in = b;
  assign if_s.a_in = a;
  assign if_s.b_in = b;
  assign if_c.a_in = a[3:0];
  assign if_c.b_in = b[3:0];

  logic   busy_m;
  logic   done_m;
  logic   rdy_m;
  longint acc_m;

  always_comb begin
    busy_m = if_u.busy;
    done_m = if_u.done;
    rdy_m  = if_u.in_ready;
    acc_m  = longint'(if_u.acc_out);
    if (sel == 1) begin
      busy_m = if_s.busy;
      done_m = if_s.done;
      rdy_m  = if_s.in_ready;
      acc_m  = longint'($signed(if_s.acc_out));
    end else if (sel == 2) begin
      busy_m = if_c.busy;
      done_m = if_c.done;
      rdy_m  = if_c.in_ready;
      acc_m  = longint'($signed(if_c.acc_out));
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int             sel;
    int             w;
    int             n;
    logic [3:0][7:0] va;
    logic [3:0][7:0] vb;
    logic [3:0][3:0] vst;
    bit             spur;
    int             abort_at;
    longint         exp_acc;
    int             exp_done;
  } vec_t;

  logic [7:0] pa [4];
  logic [7:0] pb [4];
  int         pst [4];

  // Reference: plain integer product of the operands as interpreted at width w.
  function automatic longint term(input logic [7:0] x, input logic [7:0] y, input int w,
                                  input bit sgn);
    longint xv;
    longint yv;
    longint m;
    m  = (longint'(1) << w) - 1;
    xv = longint'(x) & m;
    yv = longint'(y) & m;
    if (sgn && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
    if (sgn && yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
    return xv * yv;
  endfunction

  task automatic run_job(input string tag, input int n, input longint exp_acc,
                         input int exp_done, input bit spur, input int abort_at);
    int     k;
    int     stall_left;
    int     done_cnt;
    int     done_at;
    int     busy_bad;
    longint acc_done;
    longint acc_later;
    logic   busy_after;
    logic   busy_late;
    k          = 0;
    stall_left = pst[0];
    done_cnt   = 0;
    done_at    = -1;
    busy_bad   = 0;
    acc_done   = -1;
    acc_later  = -1;
    busy_after = 1'b1;
    busy_late  = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      if (abort_at != 0 && c == abort_at + 1) begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, ".rst_busy"}, longint'(busy_m), 0);
        check({tag, ".rst_ready"}, longint'(rdy_m), 0);
        check({tag, ".rst_done"}, longint'(done_m), 0);
        check({tag, ".rst_acc"}, acc_m, 0);
        return;
      end
      if (done_m) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c <= exp_done && !busy_m) busy_bad++;
      if (c == exp_done) acc_done = acc_m;
      if (c == exp_done + 1) busy_after = busy_m;
      if (c == exp_done + 2) acc_later = acc_m;
      if (c == exp_done + 3) busy_late = busy_m;
      start = spur && (c == 5 || c == exp_done);
      if (abort_at != 0 && c == abort_at) rst = 1'b1;
      if (rdy_m && k < n && stall_left == 0) begin
        in_valid   = 1'b1;
        a          = pa[k];
        b          = pb[k];
        k++;
        stall_left = (k < n) ? pst[k] : 0;
      end else begin
        if (rdy_m && k < n) stall_left--;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, ".done_cycle"}, done_at, exp_done);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".acc_at_done"}, acc_done, exp_acc);
    check({tag, ".busy_during"}, busy_bad, 0);
    check({tag, ".busy_after"}, longint'(busy_after), 0);
    check({tag, ".acc_held"}, acc_later, exp_acc);
    check({tag, ".stay_idle"}, longint'(busy_late), 0);
  endtask

  vec_t vec [7];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sel      = 0;

    // Packed lists read right-to-left: element [0] is the first pair.
    vec[0] = '{0, 8, 4, {8'd0, 8'd255, 8'd10, 8'd3}, {8'd7, 8'd255, 8'd10, 8'd5},
               '0, 1'b0, 0, 65140, 41};
    vec[1] = '{1, 8, 4, {8'd4, 8'd127, 8'h80, 8'hFD}, {8'd4, 8'hFF, 8'h80, 8'd5},
               '0, 1'b0, 0, 16258, 41};
    vec[2] = '{0, 8, 4, {8'd0, 8'd255, 8'd10, 8'd3}, {8'd7, 8'd255, 8'd10, 8'd5},
               {4'd2, 4'd0, 4'd3, 4'd0}, 1'b0, 0, 65140, 46};
    vec[3] = '{0, 8, 4, {8'd0, 8'd255, 8'd10, 8'd3}, {8'd7, 8'd255, 8'd10, 8'd5},
               '0, 1'b1, 0, 65140, 41};
    vec[4] = '{0, 8, 4, {8'd0, 8'd255, 8'd10, 8'd3}, {8'd7, 8'd255, 8'd10, 8'd5},
               '0, 1'b0, 24, 65140, 41};
    vec[5] = vec[0];
    vec[6] = '{2, 4, 1, {24'd0, 8'hF8}, {24'd0, 8'hF8}, '0, 1'b0, 0, 64, 7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset%0d.busy", s), longint'(busy_m), 0);
      check($sformatf("reset%0d.ready", s), longint'(rdy_m), 0);
      check($sformatf("reset%0d.done", s), longint'(done_m), 0);
      check($sformatf("reset%0d.acc", s), acc_m, 0);
    end

    for (int v = 0; v < 7; v++) begin
      sel = vec[v].sel;
      for (int i = 0; i < 4; i++) begin
        pa[i]  = vec[v].va[i];
        pb[i]  = vec[v].vb[i];
        pst[i] = int'(vec[v].vst[i]);
      end
      run_job($sformatf("vec%0d", v), vec[v].n, vec[v].exp_acc, vec[v].exp_done,
              vec[v].spur, vec[v].abort_at);
      repeat (2) @(negedge clk);
    end

    for (int r = 0; r < 12; r++) begin
      int     w;
      int     n;
      bit     sgn;
      longint exp_acc;
      int     exp_done;
      sel      = r % 3;
      w        = (sel == 2) ? 4 : 8;
      n        = (sel == 2) ? 1 : 4;
      sgn      = (sel != 0);
      exp_acc  = 0;
      exp_done = 1;
      for (int i = 0; i < 4; i++) begin
        pa[i]  = ($urandom_range(0, 3) == 0) ? 8'h88 : 8'($urandom);
        pb[i]  = ($urandom_range(0, 3) == 0) ? 8'h88 : 8'($urandom);
        pst[i] = int'($urandom_range(0, 2));
      end
      for (int i = 0; i < n; i++) begin
        exp_acc  = exp_acc + term(pa[i], pb[i], w, sgn);
        exp_done = exp_done + pst[i] + w + 2;
      end
      run_job($sformatf("rand%0d", r), n, exp_acc, exp_done, 1'b0, 0);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/batch_mac_engine.md
# batch_mac_engine

Parametrised sequential multiply-accumulate engine with a start/done handshake. On `start` it consumes COUNT operand pairs over a valid/ready input port, multiplies each pair with a WIDTH-cycle shift-add multiplier (unsigned or two's-complement), and accumulates the products. It asserts `done` with the sum held on `acc_out`. It is the next-generation top-level compute block driven by the course testbenches, extending fixed-width start/done datapaths with configurable width, batch length and signedness.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- COUNT, 4, operand pairs per job (≥1)
- SIGNED, 0, 0 = unsigned operands/result, 1 = two's-complement operands/result
- Derived: AW = 2*WIDTH + clog2(COUNT) (minimum 2*WIDTH when COUNT=1), accumulator width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled only in IDLE
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- in_valid  in  1  operand pair present
- in_ready  out  1  engine accepts a pair this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- acc_out  out  AW  accumulated result, sign-extended when SIGNED=1

## Operation
- States: IDLE, LOAD, MULT, ACC, DONE.
- IDLE:
  - `start=1` → clear accumulator, clear pair counter, go to LOAD.
  - Otherwise stay in IDLE; `acc_out` keeps the last result.
- LOAD:
  - `in_ready=1`.
  - When `in_valid=1`, latch both operands and go to MULT.
  - When `in_valid=0`, stall in LOAD indefinitely.
- MULT:
  - Exactly WIDTH cycles, one multiplier bit per cycle, LSB first.
  - Shift-add on operand magnitudes.
- ACC:
  - Add the product to the accumulator.
  - SIGNED=1: negate the product first when the operand signs differ.
  - Increment the pair counter.
  - Counter == COUNT → DONE; otherwise → LOAD.
- DONE: `done=1` for this single cycle, then IDLE.
- Signed magnitudes: −2^(WIDTH−1) converts to magnitude 2^(WIDTH−1), which needs WIDTH bits unsigned. The product is exact; no saturation.
- AW is sized so the accumulator cannot overflow for any COUNT inputs.
- `start` outside IDLE is ignored. This includes `start` in the DONE cycle.
- `a_in`/`b_in` are don't-care except in the LOAD accept cycle.
- `acc_out` reflects the live accumulator. It is valid at `done` and stays stable until the next accepted `start`.

## Timing
- Reset values: state IDLE; `in_ready=0`, `busy=0`, `done=0`, `acc_out=0`; pair counter 0.
- `rst` has priority over all transitions, including mid-MULT and during DONE.
- Per pair with `in_valid` held high: 1 (LOAD) + WIDTH (MULT) + 1 (ACC) = WIDTH+2 cycles.
- Let `start` be sampled at edge 0:
  - LOAD at cycle 1.
  - `done` high at cycle COUNT*(WIDTH+2)+1.
  - WIDTH=8, COUNT=4 → `done` at cycle 41.
- Each `in_valid`-low cycle in LOAD adds exactly one cycle of latency.
- `busy` rises the cycle after `start` is accepted. It falls the cycle after DONE, together with `done` deasserting.
- Back-to-back jobs: `start` held high continuously begins the next job on the first IDLE cycle after DONE.

## Structure
- Package `batch_mac_pkg`:
  - state enum (IDLE, LOAD, MULT, ACC, DONE);
  - a `clog2` function;
  - an AW-calculation function.
- Sub-module `seq_mult_unit`:
  - WIDTH-parameterised unsigned shift-add multiplier;
  - ports `clk`, `rst`, `go`, `a`, `b`, `prod[2*WIDTH]`, `ready`;
  - latency WIDTH cycles.
- The top level holds the FSM, sign handling, pair counter and accumulator.

## Test plan
1. Unsigned, WIDTH=8, COUNT=4, pairs (3,5), (10,10), (255,255), (0,7), `in_valid` always high → `done` at cycle 41, `acc_out`=65140, `busy` 1 for cycles 1–41.
2. Signed, same sizes, pairs (−3,5), (−128,−128), (127,−1), (4,4) → `acc_out`=16258 (18-bit signed), `done` single cycle.
3. Stalls: scenario 1 with `in_valid` dropped for 3 cycles before pair 2 and 2 cycles before pair 4 → `done` at cycle 46, same result.
4. Spurious start: `start` pulsed during MULT and during DONE → ignored; one `done` only; `acc_out` unchanged until the next IDLE `start`.
5. Reset mid-job: `rst` for 1 cycle during pair 3's MULT → next cycle state IDLE, `acc_out`=0, `busy`=0, `in_ready`=0. A new job with scenario 1 data then completes correctly.
6. Corner config: WIDTH=4, COUNT=1, SIGNED=1, pair (−8,−8) → `acc_out`=64 (8-bit), `done` at cycle 7.
